fifo_rd_packer: RTL and testbench
=================================

FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one FIFO entry.
REQ-002 Parameter RATIO, default 4, legal 2..8: FIFO entries packed per output word.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 fifo_empty  input  1  empty flag of the upstream FIFO read port.
REQ-006 fifo_rd_en  output  1  read strobe to the FIFO read port.
REQ-007 fifo_dout  input  DATA_WIDTH  FIFO registered read data, valid the cycle after an accepted fifo_rd_en.
REQ-008 flush  input  1  single-cycle request to emit any partial word.
REQ-009 out_valid  output  1  out_data/out_keep hold a word.
REQ-010 out_ready  input  1  downstream accepts the word when out_valid && out_ready.
REQ-011 out_data  output  DATA_WIDTH*RATIO  packed word; first-read entry in bits [DATA_WIDTH-1:0].
REQ-012 out_keep  output  RATIO  bit i set = entry slot i holds valid data.

Function
REQ-013 Internal state: accumulator (RATIO slots), cnt (0..RATIO, landed entries), inflight (1 = fifo_rd_en issued last cycle), flush_pend, output register.
REQ-014 fifo_rd_en SHALL never assert while fifo_empty=1 or flush_pend=1.
REQ-015 With cnt<RATIO, fifo_rd_en = !fifo_empty && (cnt+inflight < RATIO).
REQ-016 With cnt==RATIO (inflight=0 by construction), fifo_rd_en = !fifo_empty && out_free, where out_free = !out_valid || out_ready.
REQ-017 When inflight=1, fifo_dout SHALL be written to slot cnt and cnt incremented by 1.
REQ-018 When cnt==RATIO and out_free, accumulator SHALL move to the output register with out_keep all ones, out_valid=1 next cycle, and cnt=0.
REQ-019 While out_valid=1 and out_ready=0, out_data/out_keep/out_valid SHALL hold stable.
REQ-020 Steady state (FIFO never empty, out_ready=1): one word per RATIO+1 cycles; first out_valid RATIO+2 cycles after the first fifo_rd_en.
REQ-021 flush SHALL set flush_pend; a flush arriving while flush_pend=1 has no additional effect.
REQ-022 With flush_pend=1, inflight=0 and out_free: if cnt>0, emit the cnt entries with out_keep bits [cnt-1:0] set, upper data bits zero, and cnt=0; clear flush_pend in the same cycle; if cnt==0, emit nothing.
REQ-023 A full word (cnt==RATIO) pending at flush SHALL emit as a normal word per REQ-018 and satisfy the flush.
REQ-024 flush in the same cycle as a landing entry SHALL include that entry in the flushed word.
REQ-025 The accumulator SHALL never overflow and no FIFO entry SHALL be dropped or duplicated.

Reset
REQ-026 rst_n=0 SHALL immediately clear out_valid, out_data, out_keep, cnt, inflight, flush_pend, accumulator; fifo_rd_en=0 while in reset.
REQ-027 Reset mid-word SHALL discard partial and in-flight entries; the upstream FIFO is reset by the same event.

Structure
REQ-028 No shared package; OUT_WIDTH=DATA_WIDTH*RATIO and cnt width are local constants derived from the parameters.
REQ-029 Single module, no sub-modules; it connects directly to the async FIFO read-domain ports (rd_en, dout, empty).

Verification
REQ-030 8 entries 0x11..0x88 preloaded, out_ready=1 -> words 0x44332211, 0x88776655, keep 4'hF, period 5 cycles.
REQ-031 8 entries preloaded, out_ready=0 for 20 cycles -> first word held stable, fifo_rd_en stops after 4 further entries land, then both words delivered in order when out_ready=1.
REQ-032 3 entries 0xA1,0xB2,0xC3, then flush -> out_data 0x00C3B2A1, out_keep 4'b0111.
REQ-033 flush with cnt=0 and FIFO empty -> no out_valid; flush asserted in the cycle the 2nd entry lands -> keep 4'b0011.
REQ-034 FIFO empty toggling randomly for 1000 entries, random out_ready -> scoreboard sees all entries in order, fifo_rd_en never asserted while fifo_empty=1.
REQ-035 rst_n asserted with cnt=2 and inflight=1 -> outputs zero immediately; after release, the next 4 entries form a clean word.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// Reads entries from an async FIFO read port and packs RATIO of them into one output word.
// A flush emits any partial word with out_keep marking the filled slots.
module fifo_rd_packer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RATIO      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          fifo_empty,
  output logic                          fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]         fifo_dout,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH*RATIO-1:0]   out_data,
  output logic [RATIO-1:0]              out_keep
);

  localparam int unsigned OUT_WIDTH = DATA_WIDTH * RATIO;
  localparam int unsigned CNT_W     = $clog2(RATIO + 1);

  logic [RATIO-1:0][DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic                             inflight_q, inflight_d;
  logic                             flush_pend_q, flush_pend_d;
  logic                             out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]             out_data_q, out_data_d;
  logic [RATIO-1:0]                 out_keep_q, out_keep_d;

  logic                             out_free_c;
  logic                             full_c;
  logic                             rd_en_c;
  logic [RATIO-1:0][DATA_WIDTH-1:0] part_data_c;
  logic [RATIO-1:0]                 part_keep_c;

  // Read strobe: landed plus in-flight entries must fit; a full word must have somewhere to go.
  always_comb begin
    out_free_c = !out_valid_q || out_ready;
    full_c     = (cnt_q == CNT_W'(RATIO));
    if (full_c) begin
      rd_en_c = !fifo_empty && !flush_pend_q && out_free_c;
    end else begin
      rd_en_c = !fifo_empty && !flush_pend_q &&
                ((CNT_W'(cnt_q) + CNT_W'(inflight_q)) < CNT_W'(RATIO));
    end
  end

  assign fifo_rd_en = rd_en_c && rst_n;

  // Partial word for flush: slots at or above cnt are stale and masked to zero.
  always_comb begin
    part_data_c = '0;
    part_keep_c = '0;
    for (int i = 0; i < int'(RATIO); i++) begin
      if (CNT_W'(i) < cnt_q) begin
        part_data_c[i] = acc_q[i];
        part_keep_c[i] = 1'b1;
      end
    end
  end

  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    inflight_d   = rd_en_c;
    flush_pend_d = flush_pend_q || flush;
    out_valid_d  = out_valid_q && !out_ready;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;

    if (inflight_q) begin
      for (int i = 0; i < int'(RATIO); i++) begin
        if (CNT_W'(i) == cnt_q) begin
          acc_d[i] = fifo_dout;
        end
      end
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (full_c && out_free_c) begin
      out_data_d   = acc_q;
      out_keep_d   = '1;
      out_valid_d  = 1'b1;
      cnt_d        = '0;
      flush_pend_d = 1'b0;
    end else if (flush_pend_q && !inflight_q && out_free_c) begin
      if (cnt_q != '0) begin
        out_data_d  = part_data_c;
        out_keep_d  = part_keep_c;
        out_valid_d = 1'b1;
      end
      cnt_d        = '0;
      flush_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      inflight_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      inflight_q   <= inflight_d;
      flush_pend_q <= flush_pend_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: FIFO read-port model, expected words queued at push time.
module tb_fifo_rd_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  fifo_dout = '0;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;

  fifo_rd_packer #(.DATA_WIDTH(8), .RATIO(4)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_keep(out_keep)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
  } exp_t;

  exp_t       exp_q[$];
  int         acc_cyc[$];
  logic [7:0] mem [0:4095];
  int         push_cnt = 0;
  int         pop_cnt = 0;
  logic       empty_force = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         rd_viol = 0;
  int         stall_viol = 0;
  int         words_seen = 0;
  int         valid_seen = 0;
  int         first_rd = -1;
  logic       stall_prev = 1'b0;
  logic [31:0] stall_data = '0;
  logic [3:0]  stall_keep = '0;
  logic [7:0]  model_acc [0:3];
  int          model_n = 0;

  assign fifo_empty = (push_cnt == pop_cnt) || empty_force;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  // Upstream FIFO: registered read data one cycle after an accepted read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && fifo_rd_en) begin
      if (fifo_empty) rd_viol++;
      fifo_dout <= mem[pop_cnt];
      pop_cnt   <= pop_cnt + 1;
    end
  end

  task automatic push_entry(input logic [7:0] d);
    exp_t e;
    mem[push_cnt] = d;
    push_cnt++;
    model_acc[model_n] = d;
    model_n++;
    if (model_n == 4) begin
      e.data = {model_acc[3], model_acc[2], model_acc[1], model_acc[0]};
      e.keep = 4'hF;
      exp_q.push_back(e);
      model_n = 0;
    end
  endtask

  task automatic model_flush();
    exp_t e;
    if (model_n > 0) begin
      e.data = '0;
      e.keep = '0;
      for (int i = 0; i < model_n; i++) begin
        e.data[8*i +: 8] = model_acc[i];
        e.keep[i] = 1'b1;
      end
      exp_q.push_back(e);
      model_n = 0;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_words(input string tag, input int tgt, input int budget);
    int k = 0;
    while (words_seen < tgt && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, 64'(words_seen), 64'(tgt));
  endtask

  // Output monitor: scoreboard compare, stall stability, timing capture.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (fifo_rd_en && first_rd < 0) first_rd = cyc;
      if (out_valid) valid_seen++;
      if (stall_prev && (!out_valid || out_data !== stall_data || out_keep !== stall_keep))
        stall_viol++;
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      stall_keep = out_keep;
      if (out_valid && out_ready) begin
        acc_cyc.push_back(cyc);
        words_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(out_data), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("word_data", 64'(out_data), 64'(e.data));
          check("word_keep", 64'(out_keep), 64'(e.keep));
        end
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    int base;
    int vs;
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    mem[0] = 8'hEE;
    push_cnt = 1;
    tick(3);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_keep", 64'(out_keep), 64'd0);
    check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    push_cnt = 0;
    rst_n = 1'b1;
    tick(2);

    // Steady state: two full words, latency and period.
    out_ready = 1'b1;
    first_rd = -1;
    acc_cyc.delete();
    for (int i = 1; i <= 8; i++) push_entry(8'(i * 8'h11));
    wait_words("steady_words", 2, 100);
    check("first_latency", 64'(acc_cyc[0] - first_rd), 64'd6);
    check("word_period", 64'(acc_cyc[1] - acc_cyc[0]), 64'd5);
    tick(3);

    // Backpressure: output held, reads stop after the next word fills.
    out_ready = 1'b0;
    base = pop_cnt;
    for (int i = 1; i <= 12; i++) push_entry(8'(i * 8'h11));
    tick(20);
    check("stall_reads", 64'(pop_cnt - base), 64'd8);
    check("stall_valid", 64'(out_valid), 64'd1);
    check("stall_data", 64'(out_data), 64'h44332211);
    out_ready = 1'b1;
    wait_words("stall_words", 5, 100);
    tick(3);

    // Partial flush of three entries.
    push_entry(8'hA1);
    push_entry(8'hB2);
    push_entry(8'hC3);
    tick(8);
    flush = 1'b1;
    model_flush();
    tick(1);
    flush = 1'b0;
    wait_words("flush3_words", 6, 50);
    tick(3);

    // Flush with nothing accumulated emits nothing.
    vs = valid_seen;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(10);
    check("empty_flush", 64'(valid_seen - vs), 64'd0);

    // Flush in the cycle the second entry lands.
    push_entry(8'h5A);
    push_entry(8'h6B);
    tick(2);
    flush = 1'b1;
    model_flush();
    tick(1);
    flush = 1'b0;
    wait_words("flush2_words", 7, 50);
    tick(3);

    // Reset with a held word, cnt=2 and one entry in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) push_entry(8'(8'h30 + i));
    tick(8);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_data", 64'(out_data), 64'd0);
    check("mid_rst_keep", 64'(out_keep), 64'd0);
    check("mid_rst_rd_en", 64'(fifo_rd_en), 64'd0);
    exp_q.delete();
    model_n = 0;
    tick(2);
    push_cnt = pop_cnt;
    rst_n = 1'b1;
    tick(2);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) push_entry(8'(i));
    wait_words("post_rst_words", 8, 50);
    tick(3);

    // Random FIFO availability and backpressure over 1000 entries.
    for (int i = 0; i < 1000; i++) push_entry(8'($urandom_range(0, 255)));
    begin
      int k = 0;
      while (words_seen < 258 && k < 20000) begin
        tick(1);
        out_ready = ($urandom_range(0, 3) != 0);
        empty_force = ($urandom_range(0, 2) == 0);
        k++;
      end
    end
    empty_force = 1'b0;
    out_ready = 1'b1;
    wait_words("random_words", 258, 100);
    tick(5);

    check("rd_en_while_empty", 64'(rd_viol), 64'd0);
    check("stall_stability", 64'(stall_viol), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("fifo_drained", 64'(push_cnt - pop_cnt), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
